// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Writer side of the instruction path. Accepts decoded instruction fields
//   over a valid/ready handshake, packs them into RV32I words and writes them
//   sequentially into instruction memory starting at BASE_ADDR. The ALUop
//   encoding matches the control unit's decode so words round-trip.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              pulse: open a load session (only honoured in IDLE/DONE)
//   in_valid/in_ready  field handshake
//   in_kind            00 R, 01 I-ALU, 10 lw, 11 sw
//   in_aluop           ALU operation code (R / I-ALU only)
//   in_rd/rs1/rs2      register fields
//   in_imm             12-bit immediate
//   in_last            final instruction of the session
//   mem_we/addr/wdata  instruction-memory write port
//   count              words written this session
//   busy/done/err      session status; err is sticky until the next start
module instr_encoder_loader #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [3:0]        in_aluop,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [11:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W-2:0] count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE      = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] LAST_ADDR = {{(ADDR_W-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  state_t state, state_nxt;
  logic   last_q;
  logic   fields_ok;
  logic   at_last;

  // Valid ALU codes: 0..7, sub (1000) and sra (1101). sub has no immediate
  // form. Loads and stores ignore the ALU code entirely.
  function automatic logic is_legal(input logic [1:0] kind, input logic [3:0] op);
    logic known;
    known = (op[3] == 1'b0) || (op == 4'b1000) || (op == 4'b1101);
    case (kind)
      2'b00:   is_legal = known;
      2'b01:   is_legal = known && (op != 4'b1000);
      default: is_legal = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] encode(
    input logic [1:0]  kind,
    input logic [3:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [11:0] imm
  );
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [11:0] imm_i;
    f7 = op[3] ? 7'b0100000 : 7'b0000000;
    f3 = op[2:0];
    // Shift immediates carry only shamt; the upper bits select srl/sra.
    imm_i = ((f3 == 3'b001) || (f3 == 3'b101)) ? {f7, imm[4:0]} : imm;
    case (kind)
      2'b00:   encode = {f7, rs2, rs1, f3, rd, 7'b0110011};
      2'b01:   encode = {imm_i, rs1, f3, rd, 7'b0010011};
      2'b10:   encode = {imm, rs1, 3'b010, rd, 7'b0000011};
      default: encode = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endcase
  endfunction

  assign fields_ok = is_legal(in_kind, in_aluop);
  assign at_last   = (mem_addr == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = ACCEPT;
      ACCEPT: begin
        if (in_valid) begin
          if (fields_ok)    state_nxt = WRITE;
          else if (in_last) state_nxt = DONE;
        end
      end
      WRITE:   state_nxt = (last_q || at_last) ? DONE : ACCEPT;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset drops mem_we at once.
  always_comb begin
    in_ready = (state == ACCEPT);
    mem_we   = (state == WRITE);
    busy     = (state == ACCEPT) || (state == WRITE);
    done     = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= BASE;
      mem_wdata <= '0;
      count     <= '0;
      err       <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mem_addr <= BASE;
            count    <= '0;
            err      <= 1'b0;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            if (fields_ok) begin
              mem_wdata <= encode(in_kind, in_aluop, in_rd, in_rs1, in_rs2, in_imm);
              last_q    <= in_last;
            end else begin
              err <= 1'b1;
            end
          end
        end
        WRITE: begin
          count <= count + 1'b1;
          // The top word is written but the address never wraps; running
          // into it closes the session with an overflow error.
          if (at_last) err      <= 1'b1;
          else         mem_addr <= mem_addr + ADDR_W'(4);
        end
        default: ;
      endcase
    end
  end

endmodule
